// File: rtl/pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_lock_reset_seq
//
// Bring-up and supervision sequencer for the core PLL. Runs from the PLL
// reference clock, which stays valid when the PLL loses lock.
// - Pulses the PLL reset, then waits for lock (retrying on timeout).
// - Requires lock to be stable, then releases downstream reset domains one
//   after another.
// - Any loss of lock after release began re-asserts every domain and
//   restarts the PLL.
//
// Optional feature macro: PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
//   defined   : MAX_RETRIES consecutive lock timeouts park the block in FAULT
//               (left only through rst).
//   undefined : unlimited retries, fault tied to 0.
//
// Ports:
//   clk             reference clock
//   rst             synchronous, active-high reset
//   pll_locked      PLL locked flag, asynchronous to clk
//   pll_rst         reset to the PLL, active high
//   reset_stage     per-domain resets, active high, bit 0 released first
//   ready           all stages released and PLL locked
//   lock_loss_count saturating count of lock losses after release began
//   fault           retry limit exhausted
// ---------------------------------------------------------------------------
module pll_lock_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 8,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] reset_stage,
    output logic                  ready,
    output logic [7:0]            lock_loss_count,
    output logic                  fault
);

    // One shared counter serves every state, so it must hold the largest limit.
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reject parameter values the sequencing cannot honour.
    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 ||
        NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_GAP < 1 || MAX_RETRIES < 1) begin : g_param_check
        $error("pll_lock_reset_seq: parameter out of range");
    end

`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_s;
    logic               fault_r;
    logic               fault_s;
`else
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;
`endif

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic                  sync1_r;
    logic                  locked_s_r;   // synchronised pll_locked (locked_s)
    logic                  pll_rst_r;
    logic                  pll_rst_s;
    logic [NUM_STAGES-1:0] stage_r;
    logic [NUM_STAGES-1:0] stage_s;
    logic                  ready_r;
    logic                  ready_s;
    logic [7:0]            loss_r;
    logic [7:0]            loss_s;

    assign pll_rst         = pll_rst_r;
    assign reset_stage     = stage_r;
    assign ready           = ready_r;
    assign lock_loss_count = loss_r;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
    assign fault           = fault_r;
`else
    assign fault           = 1'b0;
`endif

    // Next-state, counter and next-output computation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        stage_s = stage_r;
        ready_s = ready_r;
        loss_s  = loss_r;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
        retry_s = retry_r;
`endif
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout in the same cycle.
                if (locked_s_r) begin
                    state_s = ST_STABLE;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_s = '0;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
                    if (retry_r == RETRY_W'(MAX_RETRIES - 1)) begin
                        state_s = ST_FAULT;
                    end else begin
                        state_s = ST_PLL_RST;
                        retry_s = retry_r + RETRY_W'(1);
                    end
`else
                    state_s = ST_PLL_RST;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                // A dropout here is not a lock loss: just wait for lock again.
                if (!locked_s_r) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_s = ST_RELEASE;
                    cnt_s   = '0;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
                    retry_s = '0;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!locked_s_r) begin
                    state_s = ST_PLL_RST;
                    cnt_s   = '0;
                    stage_s = '1;
                    ready_s = 1'b0;
                    loss_s  = (loss_r == 8'd255) ? loss_r : loss_r + 8'd1;
                end else if (state_r == ST_RUN) begin
                    ready_s = 1'b1;
                    stage_s = '0;
                end else if (stage_r == '0) begin
                    // Last stage cleared on the previous edge.
                    state_s = ST_RUN;
                    ready_s = 1'b1;
                end else if (cnt_r == '0) begin
                    // Shifting in a zero releases the next-higher domain.
                    stage_s = stage_r << 1;
                    cnt_s   = CNT_W'(STAGE_GAP - 1);
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
`endif
            default: begin
                state_s = ST_PLL_RST;
                cnt_s   = '0;
                stage_s = '1;
                ready_s = 1'b0;
            end
        endcase

`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
        pll_rst_s = (state_s == ST_PLL_RST) || (state_s == ST_FAULT);
        fault_s   = (state_s == ST_FAULT);
`else
        pll_rst_s = (state_s == ST_PLL_RST);
`endif
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_PLL_RST;
            cnt_r      <= '0;
            sync1_r    <= 1'b0;
            locked_s_r <= 1'b0;
            pll_rst_r  <= 1'b1;
            stage_r    <= '1;
            ready_r    <= 1'b0;
            loss_r     <= 8'd0;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
            retry_r    <= '0;
            fault_r    <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sync1_r    <= pll_locked;
            locked_s_r <= sync1_r;
            pll_rst_r  <= pll_rst_s;
            stage_r    <= stage_s;
            ready_r    <= ready_s;
            loss_r     <= loss_s;
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
            retry_r    <= retry_s;
            fault_r    <= fault_s;
`endif
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_reset_seq
// Directed self-checking bench for pll_lock_reset_seq with
// PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, NUM_STAGES=3,
// STAGE_GAP=2, MAX_RETRIES=2. Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] reset_stage;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic       fault;

    int checks   = 0;
    int failures = 0;

`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
    localparam logic FAULT_AFTER_TWO_TIMEOUTS = 1'b1;
`else
    localparam logic FAULT_AFTER_TWO_TIMEOUTS = 1'b0;
`endif

    pll_lock_reset_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .NUM_STAGES    (3),
        .STAGE_GAP     (2),
        .MAX_RETRIES   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .reset_stage    (reset_stage),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Three reset edges; on return rst is low and the last reset edge is "E0".
    task automatic do_reset(input logic locked_val);
        rst        = 1'b1;
        pll_locked = locked_val;
        step(3);
        rst = 1'b0;
    endtask

    task automatic count_while_stage(input logic [2:0] val, output int n);
        n = 0;
        while (reset_stage == val && n < 300) begin
            step(1);
            n++;
        end
    endtask

    task automatic count_while_pll_rst(input logic val, output int n);
        n = 0;
        while (pll_rst == val && n < 300) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %0b expected 1", pll_rst); end
        checks++; if (reset_stage !== 3'b111) begin failures++; $display("FAIL reset_stage: got %b expected 111", reset_stage); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b expected 0", ready); end
        checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", lock_loss_count); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %0b expected 0", fault); end
    endtask

    task automatic test_clean_bringup();
        int n;
        do_reset(1'b0);
        count_while_pll_rst(1'b1, n);
        checks++; if (n != 4) begin failures++; $display("FAIL clean_pll_rst_len: got %0d expected 4", n); end
        step(6);                       // 10 cycles after rst release
        pll_locked = 1'b1;
        count_while_stage(3'b111, n);  // 2 sync + 1 detect + 8 stable + 1 release
        checks++; if (n != 12) begin failures++; $display("FAIL clean_first_release: got %0d expected 12", n); end
        checks++; if (reset_stage !== 3'b110) begin failures++; $display("FAIL clean_stage0: got %b expected 110", reset_stage); end
        count_while_stage(3'b110, n);
        checks++; if (n != 2 || reset_stage !== 3'b100) begin failures++; $display("FAIL clean_stage1: got gap %0d stage %b expected 2 100", n, reset_stage); end
        count_while_stage(3'b100, n);
        checks++; if (n != 2 || reset_stage !== 3'b000) begin failures++; $display("FAIL clean_stage2: got gap %0d stage %b expected 2 000", n, reset_stage); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL clean_ready_early: got %0b expected 0", ready); end
        step(1);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL clean_ready: got %0b expected 1", ready); end
        checks++; if (lock_loss_count !== 8'd0 || pll_rst !== 1'b0) begin failures++; $display("FAIL clean_final: got count %0d pll_rst %0b expected 0 0", lock_loss_count, pll_rst); end
    endtask

    task automatic test_no_lock();
        int n;
        int bad;
        bad = 0;
        do_reset(1'b0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (pll_rst == 1'b1 && n < 300) begin
                if (reset_stage !== 3'b111 || ready !== 1'b0) bad++;
                step(1);
                n++;
            end
            checks++; if (n != 4) begin failures++; $display("FAIL nolock_high_%0d: got %0d expected 4", k, n); end
            n = 0;
            while (pll_rst == 1'b0 && n < 300) begin
                if (reset_stage !== 3'b111 || ready !== 1'b0) bad++;
                step(1);
                n++;
            end
            checks++; if (n != 32) begin failures++; $display("FAIL nolock_low_%0d: got %0d expected 32", k, n); end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL nolock_outputs: got %0d bad samples expected 0", bad); end
        checks++; if (fault !== FAULT_AFTER_TWO_TIMEOUTS) begin failures++; $display("FAIL nolock_fault: got %0b expected %0b", fault, FAULT_AFTER_TWO_TIMEOUTS); end
    endtask

    task automatic test_glitch();
        int n;
        do_reset(1'b0);
        count_while_pll_rst(1'b1, n);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        count_while_stage(3'b111, n);
        checks++; if (n != 12) begin failures++; $display("FAIL glitch_release: got %0d expected 12", n); end
        checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", lock_loss_count); end
        n = 0;
        while (ready == 1'b0 && n < 50) begin step(1); n++; end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL glitch_ready: got %0b expected 1", ready); end
    endtask

    task automatic test_loss_run();
        int n;
        int exp;
        pll_locked = 1'b0;
        step(2);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL run_ready_hold: got %0b expected 1", ready); end
        step(1);
        checks++; if (reset_stage !== 3'b111 || ready !== 1'b0) begin failures++; $display("FAIL run_loss_outputs: got stage %b ready %0b expected 111 0", reset_stage, ready); end
        checks++; if (lock_loss_count !== 8'd1) begin failures++; $display("FAIL run_loss_count: got %0d expected 1", lock_loss_count); end
        pll_locked = 1'b1;
        count_while_pll_rst(1'b1, n);
        checks++; if (n != 4) begin failures++; $display("FAIL run_pll_rst_len: got %0d expected 4", n); end
        n = 0;
        while (ready == 1'b0 && n < 200) begin step(1); n++; end
        checks++; if (ready !== 1'b1 || reset_stage !== 3'b000) begin failures++; $display("FAIL run_rerelease: got ready %0b stage %b expected 1 000", ready, reset_stage); end
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b0;
            n = 0;
            while (ready == 1'b1 && n < 10) begin step(1); n++; end
            exp = (i + 2 > 255) ? 255 : i + 2;
            checks++; if (ready !== 1'b0 || lock_loss_count !== exp[7:0]) begin failures++; $display("FAIL sat_loop_%0d: got ready %0b count %0d expected 0 %0d", i, ready, lock_loss_count, exp); end
            pll_locked = 1'b1;
            n = 0;
            while (ready == 1'b0 && n < 200) begin step(1); n++; end
        end
        checks++; if (lock_loss_count !== 8'd255) begin failures++; $display("FAIL sat_final: got %0d expected 255", lock_loss_count); end
    endtask

    task automatic test_loss_release_and_rst();
        int n;
        do_reset(1'b0);
        count_while_pll_rst(1'b1, n);
        pll_locked = 1'b1;
        step(10);
        pll_locked = 1'b0;
        step(1);
        checks++; if (reset_stage !== 3'b111) begin failures++; $display("FAIL rel_pre: got %b expected 111", reset_stage); end
        step(1);
        checks++; if (reset_stage !== 3'b110) begin failures++; $display("FAIL rel_stage0: got %b expected 110", reset_stage); end
        step(1);
        checks++; if (reset_stage !== 3'b111 || ready !== 1'b0 || pll_rst !== 1'b1) begin failures++; $display("FAIL rel_loss: got stage %b ready %0b pll_rst %0b expected 111 0 1", reset_stage, ready, pll_rst); end
        checks++; if (lock_loss_count !== 8'd1) begin failures++; $display("FAIL rel_count: got %0d expected 1", lock_loss_count); end
        pll_locked = 1'b1;
        count_while_pll_rst(1'b1, n);
        step(3);                       // now counting in STABLE
        rst = 1'b1;
        step(1);
        checks++; if (pll_rst !== 1'b1 || reset_stage !== 3'b111 || ready !== 1'b0 || lock_loss_count !== 8'd0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stable: got pll_rst %0b stage %b ready %0b count %0d fault %0b expected 1 111 0 0 0", pll_rst, reset_stage, ready, lock_loss_count, fault);
        end
        rst = 1'b0;
    endtask

`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
    task automatic test_fault();
        int n;
        do_reset(1'b0);
        n = 0;
        while (fault == 1'b0 && n < 200) begin step(1); n++; end
        checks++; if (n != 72) begin failures++; $display("FAIL fault_time: got %0d expected 72", n); end
        checks++; if (pll_rst !== 1'b1 || reset_stage !== 3'b111) begin failures++; $display("FAIL fault_outputs: got pll_rst %0b stage %b expected 1 111", pll_rst, reset_stage); end
        pll_locked = 1'b1;
        step(60);
        checks++; if (fault !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL fault_sticky: got fault %0b pll_rst %0b ready %0b expected 1 1 0", fault, pll_rst, ready); end
        rst = 1'b1;
        step(1);
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %0b expected 0", fault); end
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_clean_bringup();
        test_no_lock();
        test_glitch();
        test_loss_run();
        test_loss_release_and_rst();
`ifdef PLL_LOCK_RESET_SEQ_RETRY_LIMIT_EN
        test_fault();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
